// File: rtl/pid_pwm_scheduler.sv
// Multi-channel PID response to time-proportioned heater PWM with a shared period counter.
// Optional feature: define SLEW_LIMIT_EN to rate-limit on-time increases at each period boundary.
//   state   | meaning
//   S_OFF   | active on-time is 0, output held low
//   S_PULSE | 0 < active < PERIOD, output high while counter < active
//   S_FULL  | active on-time equals PERIOD, output held high
module pid_pwm_scheduler #(
  parameter int NCH       = 2,
  parameter int RESP_W    = 12,
  parameter int TIME_W    = 25,
  parameter int SHIFT     = 13,
  parameter int PERIOD    = 20_000_000,
  parameter int SLEW_STEP = 1_000_000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NCH-1:0]           EN,
  input  logic [NCH*RESP_W-1:0]    PID_RESPONSE,
  output logic [NCH*TIME_W-1:0]    TIME_VALUE,
  output logic [NCH-1:0]           HEAT_OUT,
  output logic                     PERIOD_START
);

  localparam int MAG_W  = RESP_W - 1;
  localparam int CONV_W = MAG_W + SHIFT;
  localparam int XW     = (CONV_W > TIME_W) ? CONV_W : TIME_W;
  localparam logic [TIME_W-1:0] LAST_T = TIME_W'(PERIOD - 1);
  localparam logic [TIME_W-1:0] FULL_T = TIME_W'(PERIOD);
  localparam logic [XW-1:0]     FULL_X = XW'(PERIOD);
`ifdef SLEW_LIMIT_EN
  localparam logic [TIME_W:0]   STEP_X = (TIME_W + 1)'(SLEW_STEP);
  localparam logic [TIME_W-1:0] STEP_T = TIME_W'(SLEW_STEP);
`endif

  typedef enum logic [1:0] {S_OFF, S_PULSE, S_FULL} state_t;

  // Shift is done at the wider of the two widths so the clamp compare never sees a truncated value.
  function automatic logic [TIME_W-1:0] convert(input logic [RESP_W-1:0] r);
    logic [XW-1:0] m;
    m = XW'(r[MAG_W-1:0]) << SHIFT;
    if (r[RESP_W-1])  return '0;
    if (m >= FULL_X)  return FULL_T;
    return m[TIME_W-1:0];
  endfunction

  logic [TIME_W-1:0] cnt_q, cnt_d;
  logic              run_q, run_d;
  logic              ps_q, ps_d;
  logic [NCH-1:0]    heat_q, heat_d;
  logic [TIME_W-1:0] shadow_q [NCH];
  logic [TIME_W-1:0] shadow_d [NCH];
  logic [TIME_W-1:0] active_q [NCH];
  logic [TIME_W-1:0] active_d [NCH];
  state_t            state_q  [NCH];
  state_t            state_d  [NCH];
  logic              wrap;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      ps_q   <= 1'b0;
      heat_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        state_q[i]  <= S_OFF;
      end
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      ps_q   <= ps_d;
      heat_q <= heat_d;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        state_q[i]  <= state_d[i];
      end
    end
  end

  // The first edge after reset starts period 0 without being a boundary, so active stays cleared.
  always_comb begin
    wrap   = run_q && (cnt_q == LAST_T);
    run_d  = 1'b1;
    cnt_d  = (!run_q || wrap) ? '0 : cnt_q + 1'b1;
    ps_d   = (cnt_d == '0);
    heat_d = '0;
    for (int i = 0; i < NCH; i++) begin
      shadow_d[i] = EN[i] ? convert(PID_RESPONSE[i*RESP_W +: RESP_W]) : shadow_q[i];
      active_d[i] = active_q[i];
      state_d[i]  = state_q[i];
      if (wrap) begin
`ifdef SLEW_LIMIT_EN
        if ({1'b0, shadow_q[i]} > ({1'b0, active_q[i]} + STEP_X))
          active_d[i] = active_q[i] + STEP_T;
        else
          active_d[i] = shadow_q[i];
`else
        active_d[i] = shadow_q[i];
`endif
        if (active_d[i] == '0)
          state_d[i] = S_OFF;
        else if (active_d[i] == FULL_T)
          state_d[i] = S_FULL;
        else
          state_d[i] = S_PULSE;
      end
      case (state_d[i])
        S_OFF:   heat_d[i] = 1'b0;
        S_FULL:  heat_d[i] = 1'b1;
        default: heat_d[i] = (cnt_d < active_d[i]);
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_tv
    assign TIME_VALUE[g*TIME_W +: TIME_W] = shadow_q[g];
  end

  assign HEAT_OUT     = heat_q;
  assign PERIOD_START = ps_q;

endmodule

// File: tb/tb_pid_pwm_scheduler.sv
// Self-checking bench for pid_pwm_scheduler: per-cycle behavioural model plus directed pulse-width checks.
// Build with SLEW_LIMIT_EN defined to exercise the slew-limited variant.
module tb_pid_pwm_scheduler;
  localparam int NCH = 2, RESP_W = 12, TIME_W = 25, SHIFT = 2, PERIOD = 100, SLEW_STEP = 10;
`ifdef SLEW_LIMIT_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NCH-1:0]        en  = '0;
  logic [NCH*RESP_W-1:0] pid = '0;
  logic [NCH*TIME_W-1:0] time_value;
  logic [NCH-1:0]        heat_out;
  logic                  period_start;

  pid_pwm_scheduler #(
    .NCH(NCH), .RESP_W(RESP_W), .TIME_W(TIME_W), .SHIFT(SHIFT),
    .PERIOD(PERIOD), .SLEW_STEP(SLEW_STEP)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .PID_RESPONSE(pid),
    .TIME_VALUE(time_value), .HEAT_OUT(heat_out), .PERIOD_START(period_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle index since reset release, shadow and active on-times as integers.
  bit started = 1'b0;
  bit m_rst   = 1'b1;
  int m_n     = -1;
  int m_shadow [NCH];
  int m_active [NCH];

  function automatic int conv(input logic [RESP_W-1:0] r);
    int v;
    if (r[RESP_W-1]) return 0;
    v = int'(r[RESP_W-2:0]) * (1 << SHIFT);
    return (v >= PERIOD) ? PERIOD : v;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_rst = 1'b1;
      m_n   = -1;
      for (int i = 0; i < NCH; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
    end else begin
      m_rst = 1'b0;
      m_n++;
      if (m_n > 0 && (m_n % PERIOD) == 0)
        for (int i = 0; i < NCH; i++) begin
          if (SLEW && m_shadow[i] > m_active[i] + SLEW_STEP)
            m_active[i] = m_active[i] + SLEW_STEP;
          else
            m_active[i] = m_shadow[i];
        end
      for (int i = 0; i < NCH; i++)
        if (en[i]) m_shadow[i] = conv(pid[i*RESP_W +: RESP_W]);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("period_start", period_start, m_rst ? 0 : ((m_n % PERIOD) == 0));
      for (int i = 0; i < NCH; i++) begin
        check($sformatf("time_value[%0d]", i), time_value[i*TIME_W +: TIME_W],
              m_rst ? 0 : m_shadow[i]);
        check($sformatf("heat_out[%0d]", i), heat_out[i],
              m_rst ? 0 : ((m_n % PERIOD) < m_active[i]));
      end
    end
  end

  task automatic load(input int ch, input logic [RESP_W-1:0] v);
    pid[ch*RESP_W +: RESP_W] = v;
    en = NCH'(1 << ch);
    @(posedge clk);
    #1;
    en = '0;
  endtask

  // Finds the next PERIOD_START and counts high cycles per channel over one full period.
  task automatic measure(output int c0, output int c1);
    int guard;
    guard = 0;
    c0 = 0;
    c1 = 0;
    @(negedge clk);
    while (period_start !== 1'b1 && guard < 3 * PERIOD) begin
      @(negedge clk);
      guard++;
    end
    check("period_start_found", period_start, 1);
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) @(negedge clk);
      c0 += int'(heat_out[0]);
      c1 += int'(heat_out[1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    en  = 2'b11;
    pid = {12'h123, 12'h045};
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("rst_heat", heat_out, 0);
    check("rst_ps", period_start, 0);
    check("rst_tv", time_value, 0);
    rst = 1'b0;
    en  = '0;
    pid = '0;
    @(posedge clk);
    @(negedge clk);
    check("first_ps", period_start, 1);
    check("first_heat", heat_out, 0);

    repeat (7) @(posedge clk);
    #1;
    load(0, 12'h00A);
    @(negedge clk);
    check("load_a_tv0", time_value[0 +: TIME_W], 40);
    check("load_a_tv1", time_value[TIME_W +: TIME_W], 0);
    measure(c0, c1);
    check("pulse_40_ch0", c0, SLEW ? 10 : 40);
    check("pulse_40_ch1", c1, 0);

    repeat (3) @(posedge clk);
    #1;
    load(1, 12'h80A);
    @(negedge clk);
    check("neg_tv1", time_value[TIME_W +: TIME_W], 0);
    load(1, 12'h800);
    @(negedge clk);
    check("negzero_tv1", time_value[TIME_W +: TIME_W], 0);
    measure(c0, c1);
    check("neg_pulse_ch1", c1, 0);

    repeat (3) @(posedge clk);
    #1;
    load(0, 12'h040);
    @(negedge clk);
    check("clamp_tv0", time_value[0 +: TIME_W], 100);
    measure(c0, c1);
    check("full_period_a", c0, SLEW ? 50 : 100);
    measure(c0, c1);
    check("full_period_b", c0, SLEW ? 60 : 100);

    repeat (3) @(posedge clk);
    #1;
    load(0, 12'h00A);
    @(negedge clk);
    check("reload_tv0", time_value[0 +: TIME_W], 40);
    for (int k = 0; k < 3; k++) begin
      pid = (NCH*RESP_W)'($urandom);
      @(negedge clk);
      check("hold_tv0", time_value[0 +: TIME_W], 40);
      check("hold_tv1", time_value[TIME_W +: TIME_W], 0);
    end
    measure(c0, c1);
    check("pre_wrap_40", c0, 40);
    load(0, 12'h005);
    measure(c0, c1);
    check("wrap_old_40", c0, 40);
    measure(c0, c1);
    check("wrap_new_20", c0, 20);

    for (int k = 0; k < 800; k++) begin
      if (k == 400) rst = 1'b1;
      if (k == 402) rst = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        en  = NCH'($urandom_range(1, 3));
        pid = (NCH*RESP_W)'($urandom);
        if ($urandom_range(0, 1) == 1) pid[RESP_W-1] = 1'b0;
        if ($urandom_range(0, 1) == 1) pid[0 +: 8] = 8'($urandom_range(0, 30));
      end else begin
        en = '0;
      end
      @(posedge clk);
      #1;
    end
    en = '0;

    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    load(0, 12'h00A);
    for (int k = 0; k < 4; k++) begin
      measure(c0, c1);
      check($sformatf("ramp_%0d", k), c0, SLEW ? 10 * (k + 1) : 40);
    end
    repeat (5) @(posedge clk);
    #1;
    load(0, 12'h000);
    measure(c0, c1);
    check("ramp_down_0", c0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
